// File: rtl/serdesphy_link_ctrl.sv
// SerDes PHY link bring-up sequencer: supply settle, PLL lock, CDR lock, with
// lock qualification, per-attempt timeouts, bounded retries and a sticky fault.
module serdesphy_link_ctrl #(
    parameter int unsigned PWR_SETTLE  = 64,
    parameter int unsigned LOCK_STABLE = 16,
    parameter int unsigned PLL_TIMEOUT = 4096,
    parameter int unsigned CDR_TIMEOUT = 4096,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk_ref_24m,
    input  logic       rst_n,
    input  logic       phy_en,
    input  logic       fault_clr,
    input  logic       dvdd_ok,
    input  logic       avdd_ok,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    output logic       pll_en,
    output logic       pll_rst_n,
    output logic       tx_en,
    output logic       rx_en,
    output logic       cdr_rst_n,
    output logic       link_up,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_PLL_WAIT = 3'd2,
        ST_CDR_WAIT = 3'd3,
        ST_LINK     = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam logic [15:0] PWR_LAST  = 16'(PWR_SETTLE - 1);
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] PLL_LAST  = 16'(PLL_TIMEOUT - 1);
    localparam logic [15:0] CDR_LAST  = 16'(CDR_TIMEOUT - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [15:0] stab_q, stab_d, tmo_q, tmo_d;
    logic [15:0] stab_inc_s, tmo_inc_s;
    logic [1:0]  retry_q, retry_d;
    logic [6:0]  outs_q;
    logic        pwr_ok_s, cond_s;

    // Output bundle {pll_en, pll_rst_n, tx_en, rx_en, cdr_rst_n, link_up, fault}.
    function automatic logic [6:0] decode_outs(input state_e s);
        logic [6:0] o;
        case (s)
            ST_PLL_WAIT: o = 7'b1100000;
            ST_CDR_WAIT: o = 7'b1111100;
            ST_LINK:     o = 7'b1111110;
            ST_FAULT:    o = 7'b0000001;
            default:     o = 7'b0000000;
        endcase
        return o;
    endfunction

    // Next-state, retry and qualification/timeout counter logic.
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        pwr_ok_s = dvdd_ok & avdd_ok;
        case (state_q)
            ST_PWR_WAIT: cond_s = pwr_ok_s;
            ST_PLL_WAIT: cond_s = pll_lock;
            ST_CDR_WAIT: cond_s = cdr_lock;
            default:     cond_s = 1'b0;
        endcase
        if (!cond_s) begin
            stab_inc_s = 16'd0;
        end else if (stab_q == 16'hFFFF) begin
            stab_inc_s = stab_q;
        end else begin
            stab_inc_s = stab_q + 16'd1;
        end
        if (tmo_q == 16'hFFFF) begin
            tmo_inc_s = tmo_q;
        end else begin
            tmo_inc_s = tmo_q + 16'd1;
        end

        if (!phy_en) begin
            state_d = ST_OFF;
            retry_d = 2'd0;
        end else if (!pwr_ok_s && (state_q inside {ST_PLL_WAIT, ST_CDR_WAIT, ST_LINK})) begin
            state_d = ST_PWR_WAIT;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_PWR_WAIT;
                ST_PWR_WAIT: begin
                    if (cond_s && stab_q == PWR_LAST) begin
                        state_d = ST_PLL_WAIT;
                    end else begin
                        state_d = ST_PWR_WAIT;
                    end
                end
                ST_PLL_WAIT: begin
                    if (cond_s && stab_q == LOCK_LAST) begin
                        state_d = ST_CDR_WAIT;
                    end else if (tmo_q == PLL_LAST) begin
                        // A retry goes back through PWR_WAIT so the PLL is held in reset again.
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 2'd1;
                            state_d = ST_PWR_WAIT;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else begin
                        state_d = ST_PLL_WAIT;
                    end
                end
                ST_CDR_WAIT: begin
                    if (!pll_lock) begin
                        state_d = ST_PLL_WAIT;
                    end else if (cond_s && stab_q == LOCK_LAST) begin
                        state_d = ST_LINK;
                        retry_d = 2'd0;
                    end else if (tmo_q == CDR_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 2'd1;
                            state_d = ST_PWR_WAIT;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else begin
                        state_d = ST_CDR_WAIT;
                    end
                end
                ST_LINK: begin
                    if (!pll_lock) begin
                        state_d = ST_PLL_WAIT;
                    end else if (!cdr_lock) begin
                        state_d = ST_CDR_WAIT;
                    end else begin
                        state_d = ST_LINK;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_OFF;
                        retry_d = 2'd0;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        if (state_d != state_q) begin
            stab_d = 16'd0;
            tmo_d  = 16'd0;
        end else begin
            stab_d = stab_inc_s;
            tmo_d  = (state_q inside {ST_PLL_WAIT, ST_CDR_WAIT}) ? tmo_inc_s : 16'd0;
        end
    end

    // State, counters and output registers; outputs track the registered state.
    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            stab_q  <= 16'd0;
            tmo_q   <= 16'd0;
            retry_q <= 2'd0;
            outs_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            outs_q  <= decode_outs(state_d);
        end
    end

    assign {pll_en, pll_rst_n, tx_en, rx_en, cdr_rst_n, link_up, fault} = outs_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_serdesphy_link_ctrl.sv
// Scoreboard bench for serdesphy_link_ctrl: expected status vectors are queued
// when stimulus is applied and compared once the DUT has clocked the response.
module tb_serdesphy_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, phy_en, fault_clr, dvdd_ok, avdd_ok, pll_lock, cdr_lock;
    logic       pll_en, pll_rst_n, tx_en, rx_en, cdr_rst_n, link_up, fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;
    exp_t sb_q[$];

    serdesphy_link_ctrl dut (
        .clk_ref_24m(clk), .rst_n(rst_n), .phy_en(phy_en), .fault_clr(fault_clr),
        .dvdd_ok(dvdd_ok), .avdd_ok(avdd_ok), .pll_lock(pll_lock), .cdr_lock(cdr_lock),
        .pll_en(pll_en), .pll_rst_n(pll_rst_n), .tx_en(tx_en), .rx_en(rx_en),
        .cdr_rst_n(cdr_rst_n), .link_up(link_up), .fault(fault),
        .state(state), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // {state, retry, pll_en, pll_rst_n, tx_en, rx_en, cdr_rst_n, link_up, fault}
    function automatic logic [11:0] exp_vec(input logic [2:0] st, input logic [1:0] rt);
        logic [6:0] o;
        case (st)
            3'd2:    o = 7'b1100000;
            3'd3:    o = 7'b1111100;
            3'd4:    o = 7'b1111110;
            3'd5:    o = 7'b0000001;
            default: o = 7'b0000000;
        endcase
        return {st, rt, o};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {state, retry_cnt, pll_en, pll_rst_n, tx_en, rx_en, cdr_rst_n, link_up, fault};
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the expectation, let n edges elapse, then compare against the DUT.
    task automatic expect_after(input string tag, input int n, input logic [2:0] st,
                                input logic [1:0] rt);
        exp_t e;
        e.tag = tag;
        e.v   = exp_vec(st, rt);
        sb_q.push_back(e);
        tick(n);
        e = sb_q.pop_front();
        check_eq(e.tag, obs_vec(), e.v);
    endtask

    initial begin
        rst_n = 1'b0; phy_en = 1'b0; fault_clr = 1'b0;
        dvdd_ok = 1'b0; avdd_ok = 1'b0; pll_lock = 1'b0; cdr_lock = 1'b0;
        expect_after("reset", 2, 3'd0, 2'd0);
        rst_n = 1'b1;
        tick(1);

        // Nominal bring-up: E0 is the first edge after phy_en rises.
        dvdd_ok = 1'b1; avdd_ok = 1'b1; pll_lock = 1'b1; cdr_lock = 1'b1; phy_en = 1'b1;
        expect_after("nom_pwr",      1,  3'd1, 2'd0);
        expect_after("nom_pwr_end",  63, 3'd1, 2'd0);
        expect_after("nom_pll",      1,  3'd2, 2'd0);
        expect_after("nom_pll_end",  15, 3'd2, 2'd0);
        expect_after("nom_cdr",      1,  3'd3, 2'd0);
        expect_after("nom_cdr_end",  15, 3'd3, 2'd0);
        expect_after("nom_link",     1,  3'd4, 2'd0);

        // Supply glitch in LINK, then full relock in 96 cycles.
        avdd_ok = 1'b0;
        expect_after("avdd_drop",    1,  3'd1, 2'd0);
        avdd_ok = 1'b1;
        expect_after("relock_cdr",   95, 3'd3, 2'd0);
        expect_after("relock_link",  1,  3'd4, 2'd0);

        // CDR lock loss in LINK.
        cdr_lock = 1'b0;
        expect_after("cdr_drop",     1,  3'd3, 2'd0);
        cdr_lock = 1'b1;
        expect_after("cdr_relink",   16, 3'd4, 2'd0);

        // PLL lock loss in LINK, then a one-cycle glitch at stab=10.
        pll_lock = 1'b0;
        expect_after("pll_drop",     1,  3'd2, 2'd0);
        pll_lock = 1'b1;
        tick(10);
        pll_lock = 1'b0;
        expect_after("glitch",       1,  3'd2, 2'd0);
        pll_lock = 1'b1;
        expect_after("glitch_hold",  15, 3'd2, 2'd0);
        expect_after("glitch_cdr",   1,  3'd3, 2'd0);

        // phy_en removed in CDR_WAIT.
        tick(5);
        phy_en = 1'b0;
        expect_after("phy_off",      1,  3'd0, 2'd0);
        tick(2);

        // PLL never locks: four attempts, then FAULT at E0+16640.
        pll_lock = 1'b0; phy_en = 1'b1;
        expect_after("f_pwr0",       1,    3'd1, 2'd0);
        expect_after("f_pll0",       64,   3'd2, 2'd0);
        expect_after("f_pll0_end",   4095, 3'd2, 2'd0);
        expect_after("f_pwr1",       1,    3'd1, 2'd1);
        expect_after("f_pll1",       64,   3'd2, 2'd1);
        expect_after("f_pwr2",       4096, 3'd1, 2'd2);
        expect_after("f_pll2",       64,   3'd2, 2'd2);
        expect_after("f_pwr3",       4096, 3'd1, 2'd3);
        expect_after("f_pll3",       64,   3'd2, 2'd3);
        expect_after("f_pll3_end",   4095, 3'd2, 2'd3);
        expect_after("f_fault",      1,    3'd5, 2'd3);
        expect_after("f_hold",       20,   3'd5, 2'd3);
        fault_clr = 1'b1;
        expect_after("f_clr",        1,    3'd0, 2'd0);
        fault_clr = 1'b0;
        expect_after("f_restart",    1,    3'd1, 2'd0);

        // Asynchronous reset in the middle of PLL_WAIT.
        expect_after("pre_rst_pll",  64,   3'd2, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", obs_vec(), exp_vec(3'd0, 2'd0));
        #3;
        rst_n = 1'b1;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serdesphy_link_ctrl.md
# serdesphy_link_ctrl

Link bring-up sequencer for the SerDes PHY. It sits between the CSR block and the PLL/TX/RX/CDR datapath inside `serdesphy_top`. After the CSR enables the PHY, it waits for both supplies to be good and settled, then enables and resets the PLL, the TX/RX lanes and the CDR in order. It qualifies each lock indicator with a stability filter and a timeout, retries a bounded number of times, and reports link status and a sticky fault to the CSR.

## Interface
- `PWR_SETTLE`, 64: cycles both supplies must be continuously good before the PLL starts (1..65535).
- `LOCK_STABLE`, 16: cycles a lock input must be continuously high to be accepted (1..65535).
- `PLL_TIMEOUT`, 4096: maximum cycles spent in PLL_WAIT per attempt (must be > `LOCK_STABLE`).
- `CDR_TIMEOUT`, 4096: maximum cycles spent in CDR_WAIT per attempt (must be > `LOCK_STABLE`).
- `MAX_RETRY`, 3: retries after the first failed attempt before FAULT (0..3).
- `clk_ref_24m` in 1: 24 MHz reference clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `phy_en` in 1: CSR PHY enable, level.
- `fault_clr` in 1: CSR fault-clear, one-cycle pulse.
- `dvdd_ok`, `avdd_ok` in 1 each: supply-good flags, already synchronous.
- `pll_lock`, `cdr_lock` in 1 each: lock indicators, already synchronous.
- `pll_en`, `pll_rst_n` out 1 each: PLL enable and PLL reset (active-low).
- `tx_en`, `rx_en` out 1 each: lane enables.
- `cdr_rst_n` out 1: CDR reset, active-low.
- `link_up` out 1: link established.
- `fault` out 1: sticky bring-up failure.
- `state` out 3: current state code.
- `retry_cnt` out 2: retries used in the current bring-up.

## Operation
- States and codes: OFF=0, PWR_WAIT=1, PLL_WAIT=2, CDR_WAIT=3, LINK=4, FAULT=5. Codes 6 and 7 are illegal and go to OFF on the next edge.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- Output decode (anything not listed is 0; `pll_rst_n` and `cdr_rst_n` are 0 unless listed):
  - OFF, PWR_WAIT, FAULT: all outputs 0.
  - PLL_WAIT: `pll_en`=1, `pll_rst_n`=1.
  - CDR_WAIT: PLL_WAIT outputs, plus `tx_en`=`rx_en`=`cdr_rst_n`=1.
  - LINK: CDR_WAIT outputs, plus `link_up`=1.
  - `fault`=1 only in FAULT.
- Counters: 16-bit `stab` and 16-bit `tmo`. Both clear to 0 on every state change.
  - `stab` increments each cycle its qualifying condition is 1 and clears when the condition is 0.
  - `tmo` increments every cycle in PLL_WAIT and CDR_WAIT. It saturates and never wraps.
- Transition priority, evaluated every edge:
  - 1. `phy_en`=0: go to OFF and clear `retry_cnt`.
  - 2. (`dvdd_ok`&`avdd_ok`)=0 in PLL_WAIT, CDR_WAIT or LINK: go to PWR_WAIT. `retry_cnt` is unchanged.
  - 3. State-specific rule below.
- OFF: if `phy_en`=1, go to PWR_WAIT.
- PWR_WAIT: the condition is `dvdd_ok`&`avdd_ok`. When `stab`==`PWR_SETTLE`-1 and the condition is 1, go to PLL_WAIT.
- PLL_WAIT: the condition is `pll_lock`.
  - Success: `stab`==`LOCK_STABLE`-1 and the condition is 1. Go to CDR_WAIT.
  - Otherwise, timeout: `tmo`==`PLL_TIMEOUT`-1.
    - If `retry_cnt`<`MAX_RETRY`: increment `retry_cnt` and go to PWR_WAIT. This re-resets the PLL.
    - Else go to FAULT.
  - Success wins over timeout on the same edge.
- CDR_WAIT:
  - `pll_lock`=0 goes to PLL_WAIT. This is checked before everything else in this state.
  - Otherwise the PLL_WAIT rules apply with `cdr_lock` and `CDR_TIMEOUT`; success goes to LINK.
- LINK:
  - `retry_cnt` clears to 0 on entry.
  - `pll_lock`=0 goes to PLL_WAIT.
  - Otherwise `cdr_lock`=0 goes to CDR_WAIT.
  - Neither case is counted as a retry.
- FAULT: held until `fault_clr`=1 (go to OFF and clear `retry_cnt`) or `phy_en`=0.
  - If `phy_en` is still 1 after `fault_clr`, the next edge re-enters PWR_WAIT.
- Reset values: state=OFF, `stab`=`tmo`=0, `retry_cnt`=0, so every output is 0.
  - Reset asserted mid-sequence forces this immediately and asynchronously.

## Timing
- Edge E0 is the first edge that samples `phy_en`=1 in OFF. With supplies good and locks steady high from E0:
  - PLL_WAIT is entered at E0+`PWR_SETTLE`.
  - CDR_WAIT is entered at E0+`PWR_SETTLE`+`LOCK_STABLE`.
  - LINK is entered at E0+`PWR_SETTLE`+2·`LOCK_STABLE`, which is E0+96 with defaults.
- Each qualified state lasts exactly N cycles when its condition is held: N=`PWR_SETTLE` or `LOCK_STABLE`.
- Reaction latency: loss of `phy_en`, power or lock changes the outputs after exactly one edge.
- A failed PLL attempt costs `PWR_SETTLE`+`PLL_TIMEOUT` cycles.

## Test plan
- Nominal bring-up: reset, supplies and locks high, `phy_en`=1 → `link_up` rises at E0+96. `state` walks 1,2,3,4. `retry_cnt`=0.
- PLL never locks → PWR_WAIT/PLL_WAIT repeats four times. FAULT is entered at E0+16640 with `retry_cnt`=3 and all enables 0. `fault_clr` pulse → OFF, then PWR_WAIT on the next edge.
- Lock glitch: `pll_lock` drops for 1 cycle when `stab`=10 in PLL_WAIT → `stab` restarts. CDR_WAIT is entered 16 cycles after `pll_lock` returns.
- In LINK, `avdd_ok` low for 1 cycle → PWR_WAIT next edge and all enables 0. Relock gives LINK again after 96 cycles with `retry_cnt` unchanged.
- In LINK, `cdr_lock` low → CDR_WAIT with `link_up`=0 and `tx_en`=1. In LINK, `pll_lock` low → PLL_WAIT with `tx_en`=0.
- `phy_en` low in CDR_WAIT → OFF next edge. Asserting `rst_n` low asynchronously mid-PLL_WAIT → all outputs 0 before the next clock edge.
